// File: rtl/trace_capture_fifo.sv
// trace_capture_fifo: on-chip capture buffer for the instruction trace stream.
// Words enter through a single write port and are drained first-word-fall-through
// over a valid/ready port. When the buffer is full, incoming words are counted
// as drops. A marker word carrying that count is written as soon as a slot
// frees up. Capture freezes once trap is sampled high.
module trace_capture_fifo #(
    parameter int DEPTH  = 64,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    trace_valid,
    input  logic [35:0]             trace_data,
    input  logic                    trap,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [35:0]             m_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    stopped,
    output logic                    done
);
    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    L_FULL = (AW+1)'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic [35:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_level;
    logic [DROP_W-1:0] r_drop;
    logic              r_overflow;
    logic              r_stopped;

    logic              w_capt;
    logic              w_free;
    logic              w_pend;
    logic              w_pop;
    logic              w_wr_marker;
    logic              w_wr_data;
    logic              w_push;
    logic              w_drop_now;
    logic [35:0]       w_wdata;

    // The stopped flag is the pre-edge value, so a word on the trapping edge is still captured.
    assign w_capt      = trace_valid & ~r_stopped;
    // A same-cycle pop never frees a slot for the write.
    assign w_free      = (r_level != L_FULL);
    assign w_pend      = (r_drop != '0);
    assign w_pop       = (r_level != '0) & m_ready;
    assign w_wr_marker = w_pend & w_free;
    assign w_wr_data   = ~w_pend & w_capt & w_free;
    assign w_push      = w_wr_marker | w_wr_data;
    assign w_drop_now  = w_capt & ~w_wr_data;
    assign w_wdata     = w_wr_marker ? {4'hF, 32'(r_drop)} : trace_data;

    // Control state: pointers, occupancy, drop counter and sticky flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_drop     <= '0;
            r_overflow <= 1'b0;
            r_stopped  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // A marker clears the count; a word dropped on that same edge restarts it at one.
            if (w_wr_marker) begin
                r_drop <= w_capt ? DROP_W'(1) : '0;
            end else if (w_drop_now && r_drop != DROP_MAX) begin
                r_drop <= r_drop + 1'b1;
            end
            if (w_drop_now) r_overflow <= 1'b1;
            if (trap)       r_stopped  <= 1'b1;
        end
    end

    // Storage array: data only, no reset needed since level gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_wdata;
    end

    assign m_valid  = (r_level != '0);
    assign m_data   = m_valid ? r_mem[r_rptr] : '0;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign stopped  = r_stopped;
    assign done     = r_stopped & (r_level == '0) & ~w_pend;

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Scoreboard bench for trace_capture_fifo with a small DEPTH/DROP_W so that
// full, drop, saturation and marker behaviour is reachable with short vectors.
module tb_trace_capture_fifo;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          trace_valid = 1'b0;
    logic [35:0]   trace_data = '0;
    logic          trap = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [35:0]   m_data;
    logic [LW-1:0] level;
    logic          overflow;
    logic          stopped;
    logic          done;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [35:0]   expq[$];

    trace_capture_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .trace_valid (trace_valid),
        .trace_data  (trace_data),
        .trap        (trap),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .level       (level),
        .overflow    (overflow),
        .stopped     (stopped),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [35:0] w);
        trace_valid = 1'b1;
        trace_data  = w;
        tick();
        trace_valid = 1'b0;
        trace_data  = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        expq.delete();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 40 && level != '0; i++) tick();
        chk(nm, level, 0);
    endtask

    // Monitor: a transfer seen at the falling edge is the one the next rising edge commits.
    always @(negedge clk) begin
        if (resetn && m_valid && m_ready) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got %0h expected no output", m_data);
            end else begin
                chk("sb_data", m_data, expq.pop_front());
            end
        end
    end

    initial begin
        logic [35:0] w;
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Reset state
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_stopped", stopped, 0);
        chk("rst_done", done, 0);

        // Back-to-back pass-through with the consumer always ready
        m_ready = 1'b1;
        expq.push_back(36'h0_0000_0010);
        push(36'h0_0000_0010);
        chk("t1_valid", m_valid, 1);
        chk("t1_data", m_data, 36'h0_0000_0010);
        chk("t1_level0", level, 1);
        expq.push_back(36'h1_0000_0020);
        push(36'h1_0000_0020);
        chk("t1_level1", level, 1);
        expq.push_back(36'h2_0000_0030);
        push(36'h2_0000_0030);
        chk("t1_level2", level, 1);
        wait_empty("t1_drain");
        chk("t1_overflow", overflow, 0);

        // Overflow: 7 words into 4 slots, then marker with count 3
        m_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            w = {4'h3, 32'h0000_0100 + 32'(i)};
            if (i <= 4) expq.push_back(w);
            push(w);
            if (i >= 2) chk("t2_hold", m_data, 36'h3_0000_0101);
        end
        chk("t2_level_full", level, 4);
        chk("t2_overflow", overflow, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t2_level_pop", level, 3);
        expq.push_back(36'hF_0000_0003);
        tick();
        chk("t2_level_marker", level, 4);
        m_ready = 1'b1;
        wait_empty("t2_drain");
        expq.push_back(36'h3_0000_0108);
        push(36'h3_0000_0108);
        wait_empty("t2_drain_new");
        chk("t2_overflow_sticky", overflow, 1);
        chk("t2_done", done, 0);

        // Drop counter saturation at 2^DROP_W-1
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            w = {4'h5, 32'h0000_0200 + 32'(i)};
            if (i < 4) expq.push_back(w);
            push(w);
        end
        chk("t3_level_full", level, 4);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        expq.push_back(36'hF_0000_000F);
        tick();
        chk("t3_level_marker", level, 4);
        m_ready = 1'b1;
        wait_empty("t3_drain");

        // Trap on the same edge as a trace word
        do_reset();
        m_ready = 1'b0;
        trap = 1'b1;
        expq.push_back(36'h6_0000_0777);
        push(36'h6_0000_0777);
        trap = 1'b0;
        chk("t4_stopped", stopped, 1);
        chk("t4_level", level, 1);
        for (int i = 0; i < 5; i++) push({4'h6, 32'h0000_0800 + 32'(i)});
        chk("t4_level_ignored", level, 1);
        chk("t4_overflow", overflow, 0);
        chk("t4_done_pending", done, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_stopped_sticky", stopped, 1);

        // Asynchronous reset mid-cycle with entries present
        do_reset();
        m_ready = 1'b0;
        push(36'h7_0000_0001);
        push(36'h7_0000_0002);
        trap = 1'b1;
        push(36'h7_0000_0003);
        trap = 1'b0;
        chk("t5_level_pre", level, 3);
        chk("t5_stopped_pre", stopped, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t5_m_valid", m_valid, 0);
        chk("t5_m_data", m_data, 0);
        chk("t5_level", level, 0);
        chk("t5_stopped", stopped, 0);
        chk("t5_overflow", overflow, 0);
        chk("t5_done", done, 0);
        #2;
        resetn = 1'b1;
        tick();

        // Simultaneous push and pop at level 2, then at level DEPTH-1
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w = {4'h8, 32'h0000_0900 + 32'(i)};
            expq.push_back(w);
            push(w);
        end
        m_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            w = {4'h8, 32'h0000_0900 + 32'(i)};
            expq.push_back(w);
            push(w);
            chk("t6_level2", level, 2);
        end
        wait_empty("t6_drain2");
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w = {4'h9, 32'h0000_0A00 + 32'(i)};
            expq.push_back(w);
            push(w);
        end
        m_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            w = {4'h9, 32'h0000_0A00 + 32'(i)};
            expq.push_back(w);
            push(w);
            chk("t6_level3", level, 3);
        end
        wait_empty("t6_drain3");
        chk("t6_overflow", overflow, 0);
        tick();
        chk("sb_left", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trace_capture_fifo.md
# trace_capture_fifo

Hardware capture buffer for the core's instruction trace stream. It sits directly downstream of the CPU wrapper's `trace_valid`/`trace_data` outputs and replaces file-based trace dumping with an on-chip FIFO drained over a valid/ready port. Overflow is handled by counting dropped entries and inserting a marker word into the stream. Capture freezes on `trap` so the final trace can be drained.

## Interface
- `DEPTH`, 64: FIFO entries; power of two, ≥ 4.
- `DROP_W`, 16: drop-counter width, 1..32; zero-extended into the marker word.

- `clk`  in  1  single clock, all state on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `trace_valid`  in  1  trace word present this cycle.
- `trace_data`  in  36  trace word; [35:32] flags, [31:0] payload.
- `trap`  in  1  core trapped; capture stops.
- `m_valid`  out  1  head entry available.
- `m_ready`  in  1  consumer accepts head.
- `m_data`  out  36  head entry; 0 whenever `m_valid`=0.
- `level`  out  $clog2(DEPTH)+1  current entry count.
- `overflow`  out  1  sticky: at least one entry dropped since reset.
- `stopped`  out  1  sticky: `trap` has been sampled high.
- `done`  out  1  `stopped` && FIFO empty && no pending drops.

## Operation
- Reset (async, immediate): pointers, `level`, drop counter, `overflow`, `stopped` all 0. Outputs: `m_valid`=0, `m_data`=0, `level`=0, `overflow`=0, `stopped`=0, `done`=0.
- Capturing = !`stopped`. `stopped` sets at the first posedge with `trap`=1 and holds until reset. A `trace_valid` on that same edge is still captured. Later trace words are ignored and not counted as drops.
- Marker word: {4'b1111, 32-bit zero-extended drop count}. Flag value 4'b1111 is reserved for markers.
- Write port accepts one entry per cycle. A slot is free iff `level` < DEPTH; a same-cycle pop does not free a slot for the write.
- Priority each posedge:
  - 1) If drop counter ≠ 0 and a slot is free: write the marker. Drop counter becomes 1 if a capturable `trace_valid` is also present (that word is dropped), else 0.
  - 2) Else if capturable `trace_valid` and a slot is free: write `trace_data`.
  - 3) Else if capturable `trace_valid`: drop. Drop counter increments, saturating at 2^DROP_W−1; `overflow` <= 1.
- Pending markers are still written after `stopped`, so `done` waits for them.
- Read side is first-word-fall-through: `m_valid` = (`level` ≠ 0); `m_data` = head entry. Pop on posedge when `m_valid` && `m_ready`.
- Push and pop in the same cycle: `level` unchanged, order preserved, including at `level` = DEPTH−1 and at `level` = 1.
- Pointers wrap modulo DEPTH; `level` carries the extra bit so that full and empty are distinct.

## Timing
- Write latency: a word sampled at edge N is visible on `m_data` with `m_valid`=1 from edge N (one cycle after presentation) when the FIFO was empty.
- Pop: `m_valid`&&`m_ready` at edge N advances the head; the new head (or `m_valid`=0) is visible after edge N.
- `level`, `overflow`, `stopped` and `done` are registered, updated on the same edge as the event that changes them. `done` is combinational from registered state.
- Throughput: one push and one pop per cycle sustained. No combinational path from `m_ready` to any output.
- `m_data` must hold stable while `m_valid`=1 and `m_ready`=0.

## Test plan
- Reset, `m_ready`=1, push 36'h0_0000_0010, 36'h1_0000_0020, 36'h2_0000_0030 back-to-back -> `m_data` shows them in order on consecutive cycles, one cycle after each push; `level` ≤ 1; `overflow`=0.
- DEPTH=4, `m_ready`=0, push 7 words -> `level`=4, `overflow`=1, 3 drops. Then pop once with no `trace_valid` -> next edge writes 36'hF_0000_0003; drained order is words 1–4, marker, then any new words.
- DROP_W=4, FIFO full, push 20 words, then free one slot -> marker 36'hF_0000_000F (saturated).
- `trap`=1 and `trace_valid`=1 at the same edge -> that word is captured, `stopped`=1; 5 later `trace_valid` pulses are ignored with `overflow` unchanged; `done`=1 after the last pop.
- `level`=3 with `resetn` pulsed low mid-cycle -> `m_valid`=0, `m_data`=0, `level`=0, flags cleared immediately, before the next clock edge.
- `level`=2, simultaneous push and pop for 10 cycles -> `level` stays 2 and the output order equals the input order.
